// File: rtl/uart_imem_loader.sv
// uart_imem_loader: boot-time loader that packs UART bytes into little-endian
// 32-bit words and writes them to instruction memory at consecutive word
// addresses. The CPU core is held in reset until END_COUNT back-to-back
// END_WORD writes are seen. Filling more words than the memory holds is an
// error.
// Optional feature: define LOADER_CHECKSUM_EN to add a 32-bit `checksum`
// output that is the XOR of every word written.
module uart_imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned END_COUNT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              write_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

  // Word count at which the memory is full.
  localparam logic [ADDR_W:0] Depth    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      EndCount = END_COUNT[1:0];

  state_e state_q, state_d;

  logic [1:0]        byte_idx_q;
  logic [23:0]       byte_buf_q;   // bytes 0..2 of the word being assembled
  logic [ADDR_W-1:0] word_ptr_q;
  logic [ADDR_W:0]   word_count_q;
  logic [1:0]        end_run_q;
  logic              done_pend_q;  // last write reached END_COUNT terminators
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q;
`endif

  logic        byte_accept;
  logic        word_cpl;
  logic        mem_full;
  logic        wr_fire;
  logic [31:0] word_asm;
  logic [1:0]  end_run_nxt;

  // Byte acceptance and word-completion decode for the current cycle.
  always_comb begin
    byte_accept = (state_q == StLoad) && rx_valid && !rx_break;
    word_cpl    = byte_accept && (byte_idx_q == 2'd3);
    mem_full    = (word_count_q == Depth);
    wr_fire     = word_cpl && !mem_full;
    word_asm    = {rx_data, byte_buf_q};
    end_run_nxt = (word_asm == END_WORD) ? end_run_q + 2'd1 : 2'd0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; DONE and ERROR are left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_en) state_d = StLoad;
      end
      StLoad: begin
        if (done_pend_q) begin
          state_d = StDone;
        end else if (word_cpl && mem_full) begin
          state_d = StError;
        end
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: core released and done flag only in DONE, error flag in ERROR.
  always_comb begin
    cpu_rst_n  = 1'b0;
    write_done = 1'b0;
    load_err   = 1'b0;
    unique case (state_q)
      StDone: begin
        cpu_rst_n  = 1'b1;
        write_done = 1'b1;
      end
      StError: load_err = 1'b1;
      default: ;
    endcase
  end

  // Byte assembly, write generation, terminator tracking and counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      byte_idx_q   <= 2'd0;
      byte_buf_q   <= 24'd0;
      word_ptr_q   <= '0;
      word_count_q <= '0;
      end_run_q    <= 2'd0;
      done_pend_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= 32'd0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      if (state_q == StLoad) begin
        if (rx_break) begin
          // BREAK drops any partial word and any terminator run in progress.
          byte_idx_q <= 2'd0;
          end_run_q  <= 2'd0;
        end else if (rx_valid) begin
          byte_idx_q <= byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: byte_buf_q[7:0]   <= rx_data;
            2'd1: byte_buf_q[15:8]  <= rx_data;
            2'd2: byte_buf_q[23:16] <= rx_data;
            default: ;
          endcase
          if (wr_fire) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= word_ptr_q;
            imem_wdata_q <= word_asm;
            word_ptr_q   <= word_ptr_q + ADDR_W'(1);
            word_count_q <= word_count_q + (ADDR_W + 1)'(1);
            end_run_q    <= end_run_nxt;
            done_pend_q  <= (end_run_nxt == EndCount);
`ifdef LOADER_CHECKSUM_EN
            checksum_q   <= checksum_q ^ word_asm;
`endif
          end
        end
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed scenarios plus random
// loads, checked by a scoreboard fed from a word-level reference model.
module tb_uart_imem_loader;

  localparam int          ADDR_W    = 2;
  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] END_WORD  = 32'hFFFF_FFFF;
  localparam int          END_COUNT = 2;

  localparam int MIdle = 0, MLoad = 1, MDone = 2, MErr = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              load_en;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              write_done;
  logic              load_err;
  logic [ADDR_W:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  uart_imem_loader #(
    .ADDR_W   (ADDR_W),
    .END_WORD (END_WORD),
    .END_COUNT(END_COUNT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .load_en   (load_en),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_break  (rx_break),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .write_done(write_done),
    .load_err  (load_err),
    .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       chk;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model: word-level view of the loader.
  int         m_state;
  logic [7:0] m_bytes[$];
  int         m_count;
  int         m_run;
  logic [31:0] m_chk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_bytes.delete();
    m_count = 0;
    m_run   = 0;
    m_chk   = 32'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic brk);
    exp_t        e;
    logic [31:0] w;
    if (m_state != MLoad) return;
    if (brk) begin
      m_bytes.delete();
      m_run = 0;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (m_count == DEPTH) begin
        m_state = MErr;
      end else begin
        m_chk  = m_chk ^ w;
        e.addr = ADDR_W'(m_count);
        e.data = w;
        e.cnt  = (ADDR_W + 1)'(m_count + 1);
        e.chk  = m_chk;
        exp_q.push_back(e);
        m_count++;
        m_run = (w == END_WORD) ? m_run + 1 : 0;
        if (m_run == END_COUNT) m_state = MDone;
      end
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    exp_t e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(e.data));
        chk("wr_count", 64'(word_count), 64'(e.cnt));
        chk("wr_core_held", 64'(cpu_rst_n), 64'(0));
`ifdef LOADER_CHECKSUM_EN
        chk("wr_checksum", 64'(checksum), 64'(e.chk));
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    model_byte(b, 1'b0);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_break(input logic with_valid);
    rx_break = 1'b1;
    rx_valid = with_valid;
    rx_data  = 8'($urandom);
    @(posedge clk);
    model_byte(rx_data, 1'b1);
    #1;
    rx_break = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gaps);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i*8 +: 8]);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic start();
    load_en = 1'b1;
    @(posedge clk);
    if (m_state == MIdle) m_state = MLoad;
    #1;
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    load_en  = 1'b0;
    idle(2);
    chk("reset_no_pending_writes", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    model_reset();
    resetn = 1'b1;
  endtask

  task automatic check_status(input string nm);
    idle(3);
    chk({nm, "_write_done"}, 64'(write_done), 64'(m_state == MDone));
    chk({nm, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(m_state == MDone));
    chk({nm, "_load_err"}, 64'(load_err), 64'(m_state == MErr));
    chk({nm, "_word_count"}, 64'(word_count), 64'(m_count));
    chk({nm, "_writes_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    rx_break = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Reset state of every output.
    chk("rst_imem_we", 64'(imem_we), 64'(0));
    chk("rst_imem_addr", 64'(imem_addr), 64'(0));
    chk("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check_status("rst");

    // Bytes in IDLE are ignored; then the first word.
    send_word(32'h1122_3344, 1'b0);
    check_status("idle_ignore");
    start();
    send_word(32'hFE04_2423, 1'b0);
    chk("first_core_held", 64'(cpu_rst_n), 64'(0));
    check_status("first_word");

    // Load to the terminator pair; write_done rises one cycle after the write.
    send_word(32'hFF30_0793, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b0);
    chk("done_not_early", 64'(write_done), 64'(0));
    idle(1);
    chk("done_on_time", 64'(write_done), 64'(1));
    chk("core_released_on_time", 64'(cpu_rst_n), 64'(1));
    send_word(32'h0000_0013, 1'b0);
    check_status("done_terminal");

    // Non-terminator between terminators clears the run.
    do_reset();
    start();
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'h0010_0793, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    check_status("run_cleared");
    send_word(32'hFFFF_FFFF, 1'b0);
    check_status("run_done");

    // BREAK discards a partial word; BREAK with rx_valid drops the byte.
    do_reset();
    start();
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_break(1'b0);
    send_byte(8'h6F);
    send_break(1'b1);
    send_word(32'h00C0_006F, 1'b0);
    check_status("break");

    // Overflow: fifth word into a four-word memory.
    do_reset();
    start();
    for (int i = 0; i < 4; i++) send_word(32'h0000_1000 + 32'(i), 1'b0);
    check_status("full_exact");
    send_word(32'h0000_2000, 1'b0);
    check_status("overflow");
    send_word(32'hFFFF_FFFF, 1'b0);
    check_status("error_terminal");

    // Reset mid-load, then reload from address 0.
    do_reset();
    start();
    for (int i = 0; i < 3; i++) send_word(32'h7700_0000 + 32'(i), 1'b0);
    do_reset();
    start();
    send_word(32'hA5A5_A5A5, 1'b0);
    send_word(32'h0F0F_0F0F, 1'b1);
    check_status("reload");
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_value", 64'(checksum), 64'(32'hAAAA_AAAA));
`endif

    // Random loads: mixes of terminators, breaks, gaps and stray load_en.
    for (int it = 0; it < 30; it++) begin
      int nw;
      do_reset();
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
      start();
      nw = $urandom_range(0, 6);
      for (int k = 0; k < nw; k++) begin
        logic [31:0] w;
        if ($urandom_range(0, 5) == 0) begin
          for (int j = 0; j < $urandom_range(0, 3); j++) send_byte(8'($urandom));
          send_break(1'($urandom));
        end
        if ($urandom_range(0, 4) == 0) start();
        w = ($urandom_range(0, 1) == 1) ? END_WORD : $urandom;
        send_word(w, 1'($urandom));
      end
      for (int j = 0; j < $urandom_range(0, 3); j++) send_byte(8'($urandom));
      check_status("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
